control_sequencer: RTL and testbench

Hardwired control unit for the Mini SRC datapath. It replaces the hand-driven T-state stimulus with a clocked Moore FSM that decodes IR[31:27] and drives every datapath control strobe, one control step per clock cycle. It sits directly upstream of `DataPath`, takes `IR` back from it, and owns the fetch / decode / execute sequencing for the ALU, immediate, load/store, nop and halt instructions.

---
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the Mini SRC hardwired sequencer and the DataPath.
// The sequencer (master) drives every strobe and reads IR and Stop back.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Stop;

  logic PCout, PCin, IncPC, MARin;
  logic Read, Write, MD_read, MDRin, MDRout;
  logic IRin, Yin, Zlowin, Zlowout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Csignout;
  logic ADD, SUB, AND, OR;
  logic Run;
  logic [4:0] state;

  modport master (
    input  IR, Stop,
    output PCout, PCin, IncPC, MARin,
    output Read, Write, MD_read, MDRin, MDRout,
    output IRin, Yin, Zlowin, Zlowout,
    output Gra, Grb, Grc, Rin, Rout, BAout, Csignout,
    output ADD, SUB, AND, OR,
    output Run, state
  );

  modport slave (
    output IR, Stop,
    input  PCout, PCin, IncPC, MARin,
    input  Read, Write, MD_read, MDRin, MDRout,
    input  IRin, Yin, Zlowin, Zlowout,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Csignout,
    input  ADD, SUB, AND, OR,
    input  Run, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for Mini SRC: one control step per clock,
// every strobe decoded purely from the current state.
module control_sequencer #(
  parameter bit HALT_ON_UNKNOWN = 1'b1
) (
  input logic                  clock,
  input logic                  clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [4:0] {
    S_RESET   = 5'd0,
    S_F0      = 5'd1,
    S_F1      = 5'd2,
    S_F2      = 5'd3,
    S_E3_REG  = 5'd4,
    S_E3_BA   = 5'd5,
    S_E4_ADD  = 5'd6,
    S_E4_SUB  = 5'd7,
    S_E4_AND  = 5'd8,
    S_E4_OR   = 5'd9,
    S_E4_ADDI = 5'd10,
    S_E4_ANDI = 5'd11,
    S_E4_ORI  = 5'd12,
    S_E5_WB   = 5'd13,
    S_E5_MAR  = 5'd14,
    S_E6_LD   = 5'd15,
    S_E6_ST   = 5'd16,
    S_E7_LD   = 5'd17,
    S_E7_ST   = 5'd18,
    S_HALT    = 5'd19
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_e     state_q, state_d;
  state_e     fetch_or_halt;
  logic [4:0] opcode;
  logic       is_mem;
  logic       ir_operand_unused;

  assign opcode = bus.IR[31:27];
  assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);

  // Operand fields are consumed by the datapath's select-and-encode logic.
  assign ir_operand_unused = ^bus.IR[26:0];

  // Every instruction boundary doubles as the Stop sampling point.
  assign fetch_or_halt = bus.Stop ? S_HALT : S_F0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = fetch_or_halt;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2: begin
        unique case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_E3_REG;
          OP_LDI, OP_LD, OP_ST:     state_d = S_E3_BA;
          OP_NOP:                   state_d = fetch_or_halt;
          OP_HALT:                  state_d = S_HALT;
          default:                  state_d = HALT_ON_UNKNOWN ? S_HALT : fetch_or_halt;
        endcase
      end
      S_E3_REG: begin
        unique case (opcode)
          OP_ADD:  state_d = S_E4_ADD;
          OP_SUB:  state_d = S_E4_SUB;
          OP_AND:  state_d = S_E4_AND;
          OP_OR:   state_d = S_E4_OR;
          OP_ADDI: state_d = S_E4_ADDI;
          OP_ANDI: state_d = S_E4_ANDI;
          OP_ORI:  state_d = S_E4_ORI;
          default: state_d = fetch_or_halt;
        endcase
      end
      // ldi, ld and st share the base+offset address computation.
      S_E3_BA:   state_d = S_E4_ADDI;
      S_E4_ADDI: state_d = is_mem ? S_E5_MAR : S_E5_WB;
      S_E4_ADD, S_E4_SUB, S_E4_AND, S_E4_OR,
      S_E4_ANDI, S_E4_ORI: state_d = S_E5_WB;
      S_E5_WB:   state_d = fetch_or_halt;
      S_E5_MAR:  state_d = (opcode == OP_ST) ? S_E6_ST : S_E6_LD;
      S_E6_LD:   state_d = S_E7_LD;
      S_E6_ST:   state_d = S_E7_ST;
      S_E7_LD:   state_d = fetch_or_halt;
      S_E7_ST:   state_d = fetch_or_halt;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.Read     = 1'b0;
    bus.Write    = 1'b0;
    bus.MD_read  = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zlowin   = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.BAout    = 1'b0;
    bus.Csignout = 1'b0;
    bus.ADD      = 1'b0;
    bus.SUB      = 1'b0;
    bus.AND      = 1'b0;
    bus.OR       = 1'b0;
    unique case (state_q)
      S_F0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_F1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MD_read = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_F2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_E3_REG: begin
        bus.Grb  = 1'b1;
        bus.Rout = 1'b1;
        bus.Yin  = 1'b1;
      end
      S_E3_BA: begin
        bus.Grb   = 1'b1;
        bus.BAout = 1'b1;
        bus.Yin   = 1'b1;
      end
      S_E4_ADD, S_E4_SUB, S_E4_AND, S_E4_OR: begin
        bus.Grc    = 1'b1;
        bus.Rout   = 1'b1;
        bus.Zlowin = 1'b1;
        bus.ADD    = (state_q == S_E4_ADD);
        bus.SUB    = (state_q == S_E4_SUB);
        bus.AND    = (state_q == S_E4_AND);
        bus.OR     = (state_q == S_E4_OR);
      end
      S_E4_ADDI, S_E4_ANDI, S_E4_ORI: begin
        bus.Csignout = 1'b1;
        bus.Zlowin   = 1'b1;
        bus.ADD      = (state_q == S_E4_ADDI);
        bus.AND      = (state_q == S_E4_ANDI);
        bus.OR       = (state_q == S_E4_ORI);
      end
      S_E5_WB: begin
        bus.Zlowout = 1'b1;
        bus.Gra     = 1'b1;
        bus.Rin     = 1'b1;
      end
      S_E5_MAR: begin
        bus.Zlowout = 1'b1;
        bus.MARin   = 1'b1;
      end
      S_E6_LD: begin
        bus.Read    = 1'b1;
        bus.MD_read = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_E6_ST: begin
        bus.Gra   = 1'b1;
        bus.Rout  = 1'b1;
        bus.MDRin = 1'b1;
      end
      S_E7_LD: begin
        bus.MDRout = 1'b1;
        bus.Gra    = 1'b1;
        bus.Rin    = 1'b1;
      end
      S_E7_ST: bus.Write = 1'b1;
      default: ;
    endcase
  end

  assign bus.Run   = (state_q != S_RESET) && (state_q != S_HALT);
  assign bus.state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-cycle table of expected states
// and strobe vectors, plus hand-written halt, unknown-opcode and abort cases.
module tb_control_sequencer;

  logic clock;
  logic clear;

  control_sequencer_if bus ();
  control_sequencer_if nbus ();

  assign nbus.IR   = bus.IR;
  assign nbus.Stop = bus.Stop;

  control_sequencer #(.HALT_ON_UNKNOWN(1'b1)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  control_sequencer #(.HALT_ON_UNKNOWN(1'b0)) dut_nop (
    .clock (clock),
    .clear (clear),
    .bus   (nbus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [4:0] S_RESET = 5'd0,  S_F0 = 5'd1, S_F1 = 5'd2, S_F2 = 5'd3;
  localparam logic [4:0] S_E3_REG = 5'd4, S_E3_BA = 5'd5;
  localparam logic [4:0] S_E4_SUB = 5'd7, S_E4_OR = 5'd9;
  localparam logic [4:0] S_E4_ADDI = 5'd10, S_E4_ORI = 5'd12;
  localparam logic [4:0] S_E5_WB = 5'd13, S_E5_MAR = 5'd14;
  localparam logic [4:0] S_E6_LD = 5'd15, S_E6_ST = 5'd16;
  localparam logic [4:0] S_E7_LD = 5'd17, S_E7_ST = 5'd18, S_HALT = 5'd19;

  localparam logic [24:0] M_PCOUT   = 25'd1 << 24;
  localparam logic [24:0] M_PCIN    = 25'd1 << 23;
  localparam logic [24:0] M_INCPC   = 25'd1 << 22;
  localparam logic [24:0] M_MARIN   = 25'd1 << 21;
  localparam logic [24:0] M_READ    = 25'd1 << 20;
  localparam logic [24:0] M_WRITE   = 25'd1 << 19;
  localparam logic [24:0] M_MDREAD  = 25'd1 << 18;
  localparam logic [24:0] M_MDRIN   = 25'd1 << 17;
  localparam logic [24:0] M_MDROUT  = 25'd1 << 16;
  localparam logic [24:0] M_IRIN    = 25'd1 << 15;
  localparam logic [24:0] M_YIN     = 25'd1 << 14;
  localparam logic [24:0] M_ZLOWIN  = 25'd1 << 13;
  localparam logic [24:0] M_ZLOWOUT = 25'd1 << 12;
  localparam logic [24:0] M_GRA     = 25'd1 << 11;
  localparam logic [24:0] M_GRB     = 25'd1 << 10;
  localparam logic [24:0] M_GRC     = 25'd1 << 9;
  localparam logic [24:0] M_RIN     = 25'd1 << 8;
  localparam logic [24:0] M_ROUT    = 25'd1 << 7;
  localparam logic [24:0] M_BAOUT   = 25'd1 << 6;
  localparam logic [24:0] M_CSIGN   = 25'd1 << 5;
  localparam logic [24:0] M_ADD     = 25'd1 << 4;
  localparam logic [24:0] M_SUB     = 25'd1 << 3;
  localparam logic [24:0] M_AND     = 25'd1 << 2;
  localparam logic [24:0] M_OR      = 25'd1 << 1;
  localparam logic [24:0] M_RUN     = 25'd1;

  localparam logic [24:0] V_F0  = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN;
  localparam logic [24:0] V_F1  = M_ZLOWOUT | M_PCIN | M_READ | M_MDREAD | M_MDRIN | M_RUN;
  localparam logic [24:0] V_F2  = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [24:0] V_E3R = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [24:0] V_E3B = M_GRB | M_BAOUT | M_YIN | M_RUN;
  localparam logic [24:0] V_E4R = M_GRC | M_ROUT | M_ZLOWIN | M_RUN;
  localparam logic [24:0] V_E4I = M_CSIGN | M_ZLOWIN | M_RUN;
  localparam logic [24:0] V_E5W = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
  localparam logic [24:0] V_E5M = M_ZLOWOUT | M_MARIN | M_RUN;
  localparam logic [24:0] V_E6L = M_READ | M_MDREAD | M_MDRIN | M_RUN;
  localparam logic [24:0] V_E6S = M_GRA | M_ROUT | M_MDRIN | M_RUN;
  localparam logic [24:0] V_E7L = M_MDROUT | M_GRA | M_RIN | M_RUN;
  localparam logic [24:0] V_E7S = M_WRITE | M_RUN;

  localparam logic [31:0] I_ADDI = 32'h6100_0005;
  localparam logic [31:0] I_SUB  = 32'h2000_0000;
  localparam logic [31:0] I_OR   = 32'h3000_0000;
  localparam logic [31:0] I_ORI  = 32'h7000_0000;
  localparam logic [31:0] I_LDI  = 32'h0800_0000;
  localparam logic [31:0] I_ST   = 32'h1000_0010;
  localparam logic [31:0] I_LD   = 32'h0000_0000;
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;
  localparam logic [31:0] I_UNK  = 32'hF800_0000;

  typedef struct {
    logic [31:0] ir;
    logic        stop;
    logic [4:0]  st;
    logic [24:0] vec;
  } row_t;

  row_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic [24:0] vec_a, vec_b;
  assign vec_a = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read, bus.Write,
                  bus.MD_read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin,
                  bus.Zlowout, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                  bus.Csignout, bus.ADD, bus.SUB, bus.AND, bus.OR, bus.Run};
  assign vec_b = {nbus.PCout, nbus.PCin, nbus.IncPC, nbus.MARin, nbus.Read, nbus.Write,
                  nbus.MD_read, nbus.MDRin, nbus.MDRout, nbus.IRin, nbus.Yin, nbus.Zlowin,
                  nbus.Zlowout, nbus.Gra, nbus.Grb, nbus.Grc, nbus.Rin, nbus.Rout, nbus.BAout,
                  nbus.Csignout, nbus.ADD, nbus.SUB, nbus.AND, nbus.OR, nbus.Run};

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%07h expected 0x%07h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] ir, input logic stop, input logic [4:0] st,
                     input logic [24:0] vec);
    row_t r;
    r.ir = ir; r.stop = stop; r.st = st; r.vec = vec;
    tbl.push_back(r);
  endtask

  task automatic add_fetch(input logic [31:0] ir);
    add(ir, 1'b0, S_F0, V_F0);
    add(ir, 1'b0, S_F1, V_F1);
    add(ir, 1'b0, S_F2, V_F2);
  endtask

  task automatic run_row(input string tag, input row_t r);
    bus.IR   = r.ir;
    bus.Stop = r.stop;
    @(negedge clock);
    check({tag, " state"}, 25'(bus.state), 25'(r.st));
    check({tag, " strobes"}, vec_a, r.vec);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    row_t r;
    clear    = 1'b1;
    bus.IR   = 32'h0;
    bus.Stop = 1'b0;

    add_fetch(I_ADDI);
    add(I_ADDI, 1'b0, S_E3_REG,  V_E3R);
    add(I_ADDI, 1'b0, S_E4_ADDI, V_E4I | M_ADD);
    add(I_ADDI, 1'b0, S_E5_WB,   V_E5W);
    add_fetch(I_SUB);
    add(I_SUB, 1'b0, S_E3_REG, V_E3R);
    add(I_SUB, 1'b0, S_E4_SUB, V_E4R | M_SUB);
    add(I_SUB, 1'b0, S_E5_WB,  V_E5W);
    add_fetch(I_OR);
    add(I_OR, 1'b0, S_E3_REG, V_E3R);
    add(I_OR, 1'b0, S_E4_OR,  V_E4R | M_OR);
    add(I_OR, 1'b0, S_E5_WB,  V_E5W);
    add_fetch(I_ORI);
    add(I_ORI, 1'b0, S_E3_REG, V_E3R);
    add(I_ORI, 1'b0, S_E4_ORI, V_E4I | M_OR);
    add(I_ORI, 1'b0, S_E5_WB,  V_E5W);
    add_fetch(I_LDI);
    add(I_LDI, 1'b0, S_E3_BA,   V_E3B);
    add(I_LDI, 1'b0, S_E4_ADDI, V_E4I | M_ADD);
    add(I_LDI, 1'b0, S_E5_WB,   V_E5W);
    add_fetch(I_ST);
    add(I_ST, 1'b0, S_E3_BA,   V_E3B);
    add(I_ST, 1'b0, S_E4_ADDI, V_E4I | M_ADD);
    add(I_ST, 1'b0, S_E5_MAR,  V_E5M);
    add(I_ST, 1'b0, S_E6_ST,   V_E6S);
    add(I_ST, 1'b0, S_E7_ST,   V_E7S);
    add_fetch(I_NOP);
    add_fetch(I_LD);
    add(I_LD, 1'b1, S_E3_BA,   V_E3B);
    add(I_LD, 1'b1, S_E4_ADDI, V_E4I | M_ADD);
    add(I_LD, 1'b1, S_E5_MAR,  V_E5M);
    add(I_LD, 1'b1, S_E6_LD,   V_E6L);
    add(I_LD, 1'b1, S_E7_LD,   V_E7L);
    for (int i = 0; i < 3; i++) add(I_LD, 1'b0, S_HALT, 25'd0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("clear held state", 25'(bus.state), 25'(S_RESET));
    check("clear held strobes", vec_a, 25'd0);
    clear = 1'b0;
    #1;
    check("released before edge state", 25'(bus.state), 25'(S_RESET));
    @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_row($sformatf("row%0d", i), tbl[i]);
    end

    // halt instruction, then frozen outputs
    do_reset();
    r.stop = 1'b0; r.ir = I_HALT;
    r.st = S_F0; r.vec = V_F0; run_row("halt F0", r);
    r.st = S_F1; r.vec = V_F1; run_row("halt F1", r);
    r.st = S_F2; r.vec = V_F2; run_row("halt F2", r);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("halt hold%0d state", i), 25'(bus.state), 25'(S_HALT));
      check($sformatf("halt hold%0d strobes", i), vec_a, 25'd0);
    end

    // undefined opcode: one instance halts, the other treats it as nop
    do_reset();
    r.ir = I_UNK;
    r.st = S_F0; r.vec = V_F0; run_row("unk F0", r);
    r.st = S_F1; r.vec = V_F1; run_row("unk F1", r);
    r.st = S_F2; r.vec = V_F2; run_row("unk F2", r);
    @(negedge clock);
    check("unk halt-mode state", 25'(bus.state), 25'(S_HALT));
    check("unk nop-mode state", 25'(nbus.state), 25'(S_F0));
    check("unk nop-mode strobes", vec_b, V_F0);

    // clear pulsed during st E7 aborts immediately
    do_reset();
    r.ir = I_ST;
    r.st = S_F0;      r.vec = V_F0;          run_row("abort F0", r);
    r.st = S_F1;      r.vec = V_F1;          run_row("abort F1", r);
    r.st = S_F2;      r.vec = V_F2;          run_row("abort F2", r);
    r.st = S_E3_BA;   r.vec = V_E3B;         run_row("abort E3", r);
    r.st = S_E4_ADDI; r.vec = V_E4I | M_ADD; run_row("abort E4", r);
    r.st = S_E5_MAR;  r.vec = V_E5M;         run_row("abort E5", r);
    r.st = S_E6_ST;   r.vec = V_E6S;         run_row("abort E6", r);
    @(negedge clock);
    check("abort E7 strobes", vec_a, V_E7S);
    #2;
    clear = 1'b1;
    #1;
    check("abort Write dropped", 25'(bus.Write), 25'd0);
    check("abort state", 25'(bus.state), 25'(S_RESET));
    check("abort strobes", vec_a, 25'd0);
    #1;
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
